alu_pipe: RTL

- Parametrised, handshaked successor of the single-cycle mock ALU.
- Single-cycle ops complete in one cycle into a registered output stage.
- Multiply runs on an iterative shift-add engine over WIDTH cycles.
- Carries a caller tag per op and a one-entry output buffer with backpressure; used as the ALU datapath macro in mock-alu flow variants.

---
 rtl/alu_pipe_pkg.sv | 44 ++++
 rtl/alu_pipe_mul_seq.sv | 75 +++++++
 rtl/alu_pipe.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// alu_pipe_pkg
// Shared definitions for the handshaked pipelined ALU (alu_pipe):
//   - opcode encodings (6-bit io_op values)
//   - control FSM state type
//   - is_sub(): opcodes that run the adder in subtract mode
// Optional feature macro referenced by users of this package:
//   ALU_PIPE_MULHI_EN -- enables OP_MULHU (upper half of the product).
// -----------------------------------------------------------------------------
package alu_pipe_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD   = 6'h00;
    localparam logic [OP_W-1:0] OP_SUB   = 6'h07;
    localparam logic [OP_W-1:0] OP_AND   = 6'h08;
    localparam logic [OP_W-1:0] OP_OR    = 6'h09;
    localparam logic [OP_W-1:0] OP_XOR   = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLL   = 6'h0B;
    localparam logic [OP_W-1:0] OP_SRL   = 6'h0C;
    localparam logic [OP_W-1:0] OP_SRA   = 6'h0D;
    localparam logic [OP_W-1:0] OP_EQ    = 6'h0E;
    localparam logic [OP_W-1:0] OP_NE    = 6'h0F;
    localparam logic [OP_W-1:0] OP_LT    = 6'h10;
    localparam logic [OP_W-1:0] OP_LTU   = 6'h11;
    localparam logic [OP_W-1:0] OP_LE    = 6'h12;
    localparam logic [OP_W-1:0] OP_LEU   = 6'h13;
    localparam logic [OP_W-1:0] OP_MUL   = 6'h14;
    localparam logic [OP_W-1:0] OP_MULHU = 6'h15;

    // IDLE: accepting ops; MUL: engine iterating; DONE: product waiting for
    // the output register to free up.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // SUB and every compare share the subtracting adder.
    function automatic logic is_sub(input logic [OP_W-1:0] op);
        return (op == OP_SUB) || ((op >= OP_EQ) && (op <= OP_LEU));
    endfunction

endpackage

// File: rtl/alu_pipe_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_pipe_mul_seq
// Iterative shift-add unsigned multiplier, one partial product per cycle,
// WIDTH iterations per operation.
// Ports:
//   clock    in   sole clock
//   reset    in   synchronous, active-low; aborts any running multiply
//   start    in   load a/b, clear accumulator, begin iterating next cycle
//   a, b     in   WIDTH-bit unsigned operands (sampled on start)
//   done     out  high during the final iteration cycle; product is
//                 complete from the following cycle until the next start
//   product  out  ACC_W-bit accumulator (2*WIDTH for full product, or
//                 WIDTH when only the low half is needed)
// -----------------------------------------------------------------------------
module alu_pipe_mul_seq #(
    parameter int WIDTH = 64,
    parameter int ACC_W = 2 * WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [ACC_W-1:0] product
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic             running;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] a_sh;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] b_sh;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            running <= 1'b0;
            count   <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
        end else if (running) begin
            count <= count + 1'b1;
            if (count == LAST) begin
                running <= 1'b0;
            end
        end
    end

    // NOTE: the operand/accumulator datapath carries no reset; it is always
    // reloaded by start before use and only the control bits need a known value.
    always_ff @(posedge clock) begin
        if (start) begin
            a_sh <= ACC_W'(a);
            b_sh <= b;
            acc  <= '0;
        end else if (running) begin
            if (b_sh[0]) begin
                acc <= acc + a_sh;
            end
            // With a WIDTH-bit accumulator the bits shifted out of a_sh are
            // exactly the high partial products we do not need.
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
        end
    end

    assign done    = running && (count == LAST);
    assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Handshaked ALU with a registered one-entry output buffer. Logic, add/sub,
// shift and compare ops complete in one cycle; MUL (and MULHU when enabled)
// runs on the iterative multiplier in alu_pipe_mul_seq.
// Parameters:
//   WIDTH  operand/result width (power of two, 8..128)
//   TAG_W  opaque caller tag width
//   SH_W   shift-amount width, derived from WIDTH
// Ports:
//   clock, reset           clock; synchronous active-low reset
//   io_in_valid/ready      op handshake (ready is combinational, independent
//                          of io_in_valid)
//   io_op, io_a, io_b      opcode (alu_pipe_pkg encoding) and operands
//   io_tag                 caller tag returned with the result
//   io_out_valid/ready     result handshake; result/tag held while stalled
//   io_out, io_out_tag     result and its tag
//   io_busy                multiply engine iterating
// Optional feature macro:
//   ALU_PIPE_MULHI_EN      enables opcode 0x15 MULHU (upper half of product);
//                          without it 0x15 is an unknown opcode returning 0.
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [5:0]       io_op,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    input  logic [TAG_W-1:0] io_tag,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out,
    output logic [TAG_W-1:0] io_out_tag,
    output logic             io_busy
);

`ifdef ALU_PIPE_MULHI_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH;
`endif

    state_t           state;
    state_t           state_next;
    logic             out_free;
    logic             accept;
    logic             mul_op;
    logic             mul_start;
    logic             mul_done;
    logic [ACC_W-1:0] mul_product;
    logic [WIDTH-1:0] mul_result;
    logic [TAG_W-1:0] mul_tag;

    logic             sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             carry;
    logic [SH_W-1:0]  shamt;
    logic             cmp;
    logic [WIDTH-1:0] alu_result;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // The output register is free if empty or being drained this cycle,
    // which is what allows pop and accept on the same edge.
    assign out_free  = !io_out_valid || io_out_ready;
    assign accept    = io_in_valid && io_in_ready;

`ifdef ALU_PIPE_MULHI_EN
    assign mul_op    = (io_op == OP_MUL) || (io_op == OP_MULHU);
`else
    assign mul_op    = (io_op == OP_MUL);
`endif
    assign mul_start = accept && mul_op;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        io_in_ready = 1'b0;
        io_busy     = 1'b0;
        case (state)
            IDLE: begin
                io_in_ready = out_free;
                if (mul_start) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                io_busy = 1'b1;
                if (mul_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_free) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    alu_pipe_mul_seq #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mul_seq (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (io_a),
        .b       (io_b),
        .done    (mul_done),
        .product (mul_product)
    );

`ifdef ALU_PIPE_MULHI_EN
    logic mul_hi;

    always_ff @(posedge clock) begin
        if (mul_start) begin
            mul_hi  <= (io_op == OP_MULHU);
            mul_tag <= io_tag;
        end
    end

    assign mul_result = mul_hi ? mul_product[ACC_W-1:WIDTH] : mul_product[WIDTH-1:0];
`else
    always_ff @(posedge clock) begin
        if (mul_start) begin
            mul_tag <= io_tag;
        end
    end

    assign mul_result = mul_product;
`endif

    // ------------------------------------------------------------------
    // Single-cycle datapath: one adder serves ADD, SUB and all compares.
    // ------------------------------------------------------------------
    always_comb begin
        sub   = is_sub(io_op);
        sum   = {1'b0, io_a} + {1'b0, io_b ^ {WIDTH{sub}}} + {{WIDTH{1'b0}}, sub};
        diff  = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        shamt = io_b[SH_W-1:0];

        // Signed compares take the raw sign of the difference; overflow is
        // deliberately not corrected.
        cmp = 1'b0;
        case (io_op)
            OP_EQ:   cmp = ~|diff;
            OP_NE:   cmp = |diff;
            OP_LT:   cmp = diff[WIDTH-1];
            OP_LTU:  cmp = ~carry;
            OP_LE:   cmp = ~|diff | diff[WIDTH-1];
            OP_LEU:  cmp = ~|diff | ~carry;
            default: cmp = 1'b0;
        endcase

        alu_result = '0;
        case (io_op)
            OP_ADD, OP_SUB: alu_result = diff;
            OP_AND:         alu_result = io_a & io_b;
            OP_OR:          alu_result = io_a | io_b;
            OP_XOR:         alu_result = io_a ^ io_b;
            OP_SLL:         alu_result = io_a << shamt;
            OP_SRL:         alu_result = io_a >> shamt;
            OP_SRA:         alu_result = $signed(io_a) >>> shamt;
            OP_EQ, OP_NE, OP_LT, OP_LTU, OP_LE, OP_LEU:
                            alu_result = {{(WIDTH-1){1'b0}}, cmp};
            default:        alu_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output buffer: loaded by a single-cycle accept or by the multiplier
    // leaving DONE; the two are exclusive because accept requires IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            io_out_valid <= 1'b0;
            io_out       <= '0;
            io_out_tag   <= '0;
        end else if (accept && !mul_op) begin
            io_out_valid <= 1'b1;
            io_out       <= alu_result;
            io_out_tag   <= io_tag;
        end else if ((state == DONE) && out_free) begin
            io_out_valid <= 1'b1;
            io_out       <= mul_result;
            io_out_tag   <= mul_tag;
        end else if (io_out_ready) begin
            io_out_valid <= 1'b0;
        end
    end

endmodule
